camera_capture_ctrl: RTL and testbench

Frame-capture sequencer between the OV7670-style camera byte stream (pclk, vsync, href, 8-bit data) and the frame buffer write port. On request, it waits for a clean frame start, then pairs bytes into 16-bit RGB565 pixels. It generates linear frame-buffer write addresses and signals frame completion or error. It decides which frame is captured and where each pixel lands; the downstream detector reads the buffer after frame_done.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/camera_capture_ctrl_if.sv | 29 ++
 rtl/cam_byte_pair.sv | 46 ++++
 rtl/camera_capture_ctrl.sv | 169 ++++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture path: FSM states, frame geometry, RGB565 pixel.
package cam_pkg;

    localparam int unsigned CAM_WIDTH  = 160;
    localparam int unsigned CAM_HEIGHT = 120;
    localparam int unsigned CAM_ADDR_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/camera_capture_ctrl_if.sv
// Camera byte stream, capture handshake and frame-buffer write port of camera_capture_ctrl.
interface camera_capture_ctrl_if
    import cam_pkg::*;
#(
    parameter int unsigned ADDR_W = CAM_ADDR_W
) ();

    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              cap_req;
    logic              cap_busy;
    logic              frame_done;
    logic              frame_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    rgb565_t           wr_data;

    modport master (
        input  cam_vsync, cam_href, cam_data, cap_req,
        output cap_busy, frame_done, frame_err, wr_en, wr_addr, wr_data
    );

    modport slave (
        output cam_vsync, cam_href, cam_data, cap_req,
        input  cap_busy, frame_done, frame_err, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/cam_byte_pair.sv
// Pairs consecutive camera bytes into one RGB565 pixel: phase toggle, high-byte latch, pixel-valid pulse.
module cam_byte_pair
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       byte_vld,
    input  logic [7:0] byte_in,
    output logic       phase_q,
    output logic       pix_vld_c,
    output rgb565_t    pix_c
);

    logic       phase_d;
    logic [7:0] hi_q;
    logic [7:0] hi_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clr) begin
            phase_d = 1'b0;
        end else if (byte_vld) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = byte_in;
            end
        end
    end

    // Second byte completes the pixel in the same cycle it arrives.
    assign pix_vld_c = byte_vld & phase_q & ~clr;
    assign pix_c     = rgb565_t'({hi_q, byte_in});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: waits for a clean frame start, writes RGB565 pixels to a linear frame buffer.
// Optional 2:1 decimation in both axes under `define CAPTURE_DECIM_EN.
module camera_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH  = CAM_WIDTH,
    parameter int unsigned HEIGHT = CAM_HEIGHT,
    parameter int unsigned ADDR_W = CAM_ADDR_W
) (
    input logic                   pclk,
    input logic                   rst_n,
    camera_capture_ctrl_if.master bus
);

    localparam int unsigned COL_W = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 1);
`ifdef CAPTURE_DECIM_EN
    localparam int unsigned LINE_STEP = WIDTH / 2;
`else
    localparam int unsigned LINE_STEP = WIDTH;
`endif

    cap_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              err_q, err_d;
    logic              vsync_q, href_q;
    logic              cap_busy_q, cap_busy_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    rgb565_t           wr_data_q, wr_data_d;

    logic              vs_rise_c, href_fall_c, byte_vld_c, clr_c;
    logic              phase_q, pix_vld_c;
    rgb565_t           pix_c;
    logic              wr_sel_c;
    logic [COL_W-1:0]  col_idx_c;
    logic [ADDR_W-1:0] line_inc_c;

    assign vs_rise_c   = bus.cam_vsync & ~vsync_q;
    assign href_fall_c = ~bus.cam_href & href_q;
    assign byte_vld_c  = bus.cam_href & (state_q == ST_CAPTURE);
    assign clr_c       = (state_q != ST_CAPTURE) | href_fall_c;

`ifdef CAPTURE_DECIM_EN
    // Keep even pixels of even rows; the base advances once per row pair.
    assign wr_sel_c   = ~row_q[0] & ~col_q[0];
    assign col_idx_c  = col_q >> 1;
    assign line_inc_c = row_q[0] ? ADDR_W'(LINE_STEP) : '0;
`else
    assign wr_sel_c   = 1'b1;
    assign col_idx_c  = col_q;
    assign line_inc_c = ADDR_W'(LINE_STEP);
`endif

    cam_byte_pair u_byte_pair (
        .clk       (pclk),
        .rst_n     (rst_n),
        .clr       (clr_c),
        .byte_vld  (byte_vld_c),
        .byte_in   (bus.cam_data),
        .phase_q   (phase_q),
        .pix_vld_c (pix_vld_c),
        .pix_c     (pix_c)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        line_base_d = line_base_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cap_req) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (vs_rise_c) begin
                    row_d       = '0;
                    col_d       = '0;
                    line_base_d = '0;
                    err_d       = 1'b0;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pix_vld_c) begin
                    if (col_q < COL_W'(WIDTH)) begin
                        wr_en_d   = wr_sel_c;
                        if (wr_sel_c) begin
                            wr_data_d = pix_c;
                            wr_addr_d = line_base_q + ADDR_W'(col_idx_c);
                        end
                        col_d = col_q + COL_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Line end is resolved before a coincident vsync.
                if (href_fall_c) begin
                    if ((col_q != COL_W'(WIDTH)) || phase_q) err_d = 1'b1;
                    col_d       = '0;
                    row_d       = row_q + ROW_W'(1);
                    line_base_d = line_base_q + line_inc_c;
                    if (row_d == ROW_W'(HEIGHT)) state_d = ST_DONE;
                end
                if (vs_rise_c && (state_d != ST_DONE)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cap_busy_d   = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        frame_done_d = (state_d == ST_DONE);
        frame_err_d  = (state_d == ST_DONE) & err_d;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            line_base_q  <= '0;
            err_q        <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            cap_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            line_base_q  <= line_base_d;
            err_q        <= err_d;
            vsync_q      <= bus.cam_vsync;
            href_q       <= bus.cam_href;
            cap_busy_q   <= cap_busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.cap_busy   = cap_busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl: camera byte-stream driver, write scoreboard, line-vector table.
module tb_camera_capture_ctrl;
    import cam_pkg::*;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int AW  = 15;
    localparam int GAP = 2;
`ifdef CAPTURE_DECIM_EN
    localparam int FULL_WR = 4800, FULL_LAST = 4799;
    localparam int B_WR = 160, B_LAST = 159;
    localparam int D_WR = 2400, D_LAST = 2399;
`else
    localparam int FULL_WR = 19200, FULL_LAST = 19199;
    localparam int B_WR = 640, B_LAST = 639;
    localparam int D_WR = 9600, D_LAST = 9599;
`endif

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 pclk = ~pclk;

    camera_capture_ctrl_if #(.ADDR_W(AW)) bus ();

    camera_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef struct {
        int bytes;
        int exp_wr;
        int exp_first;
        int exp_last;
    } line_vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    wr_t           exp_q[$];
    logic [AW-1:0] wr_log[$];
    int            wr_cnt = 0;
    int            bad_cnt = 0;
    int            done_cnt = 0;
    logic          last_err = 1'b0;
    logic [AW-1:0] last_addr = '0;
    string         bad_msg = "";

    bit         exp_cap = 1'b0;
    bit         pat_aa = 1'b0;
    logic [7:0] cur_hi = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Write monitor / scoreboard, sampled on the falling edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge pclk);
            if (rst_n) begin
                if (bus.wr_en) begin
                    wr_cnt++;
                    last_addr = bus.wr_addr;
                    wr_log.push_back(bus.wr_addr);
                    if (!bus.cap_busy) begin
                        bad_cnt++;
                        bad_msg = $sformatf("write at 0x%0h with cap_busy low", bus.wr_addr);
                    end
                    if (exp_q.size() == 0) begin
                        bad_cnt++;
                        bad_msg = $sformatf("unexpected write addr 0x%0h", bus.wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.wr_addr !== e.addr || 16'(bus.wr_data) !== e.data) begin
                            bad_cnt++;
                            bad_msg = $sformatf("write 0x%0h/0x%0h, expected 0x%0h/0x%0h",
                                                bus.wr_addr, 16'(bus.wr_data), e.addr, e.data);
                        end
                    end
                end
                if (bus.frame_done) begin
                    done_cnt++;
                    last_err = bus.frame_err;
                    if (bus.cap_busy) begin
                        bad_cnt++;
                        bad_msg = "cap_busy high during frame_done";
                    end
                end
            end
        end
    end

    task automatic push_exp(input int row, input int col, input logic [15:0] data);
        wr_t e;
`ifdef CAPTURE_DECIM_EN
        if ((row % 2) != 0 || (col % 2) != 0) return;
        e.addr = AW'((row / 2) * (W / 2) + col / 2);
`else
        e.addr = AW'(row * W + col);
`endif
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_byte(input int row, input int b);
        int col;
        logic [7:0] d;
        col = b / 2;
        tick();
        bus.cam_href = 1'b1;
        if ((b % 2) == 0) begin
            cur_hi = pat_aa ? 8'hAA : 8'(row * 7 + col);
            bus.cam_data = cur_hi;
        end else begin
            d = pat_aa ? 8'h55 : (8'(col) ^ 8'hC3);
            bus.cam_data = d;
            if (exp_cap && col < W) push_exp(row, col, {cur_hi, d});
        end
    endtask

    task automatic send_line(input int nbytes, input int row, input bit vs_at_end, input int req_at);
        for (int b = 0; b < nbytes; b++) begin
            drive_byte(row, b);
            bus.cap_req = (b == req_at);
        end
        tick();
        bus.cam_href  = 1'b0;
        bus.cap_req   = 1'b0;
        bus.cam_vsync = vs_at_end;
        tick();
        bus.cam_vsync = 1'b0;
        repeat (GAP - 1) tick();
    endtask

    task automatic vsync_pulse();
        tick();
        bus.cam_vsync = 1'b1;
        repeat (2) tick();
        bus.cam_vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic req_pulse();
        tick();
        bus.cap_req = 1'b1;
        tick();
        bus.cap_req = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " cap_busy"},   32'(bus.cap_busy),   32'd0);
        check({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, " frame_err"},  32'(bus.frame_err),  32'd0);
        check({tag, " wr_en"},      32'(bus.wr_en),      32'd0);
        check({tag, " wr_addr"},    32'(bus.wr_addr),    32'd0);
        check({tag, " wr_data"},    32'(bus.wr_data),    32'd0);
    endtask

    task automatic check_frame(input string tag, input int done_base, input int wr_base,
                               input int bad_base, input int exp_wr, input bit exp_err,
                               input int exp_last);
        for (int i = 0; i < 64 && done_cnt == done_base; i++) tick();
        check({tag, " frame_done pulses"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, " frame_err"},         32'(last_err),             32'(exp_err));
        check({tag, " write count"},       32'(wr_cnt - wr_base),     32'(exp_wr));
        check({tag, " last wr_addr"},      32'(last_addr),            32'(exp_last));
        check({tag, " pending writes"},    32'(exp_q.size()),         32'd0);
        n_cmp++;
        if (bad_cnt != bad_base) begin
            n_fail++;
            $display("FAIL %s write stream: %0d bad writes, expected 0 (latest: %s)",
                     tag, bad_cnt - bad_base, bad_msg);
        end
        repeat (2) tick();
        check({tag, " cap_busy after done"}, 32'(bus.cap_busy), 32'd0);
        check({tag, " wr_addr holds"},       32'(bus.wr_addr),  32'(exp_last));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        line_vec_t tbl[8];
        int d0, w0, b0, wl;
        logic [AW-1:0] first;

        for (int r = 0; r < 8; r++) begin
            tbl[r].bytes     = 320;
            tbl[r].exp_wr    = 160;
            tbl[r].exp_first = r * W;
            tbl[r].exp_last  = r * W + 159;
        end
        tbl[5].bytes    = 322;
        tbl[6].bytes    = 318;
        tbl[6].exp_wr   = 159;
        tbl[6].exp_last = 6 * W + 158;

        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        bus.cap_req   = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle cap_busy", 32'(bus.cap_busy), 32'd0);

        // Reset during line 30 aborts silently.
        d0 = done_cnt;
        pat_aa = 1'b0;
        req_pulse();
        check("arm cap_busy", 32'(bus.cap_busy), 32'd1);
        exp_cap = 1'b1;
        vsync_pulse();
        for (int r = 0; r < 30; r++) send_line(320, r, 1'b0, -1);
        for (int b = 0; b < 100; b++) drive_byte(30, b);
        @(posedge pclk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid-frame reset");
        exp_cap = 1'b0;
        exp_q.delete();
        w0 = wr_cnt;
        drive_byte(30, 100);
        drive_byte(30, 101);
        rst_n = 1'b1;
        for (int b = 102; b < 320; b++) drive_byte(30, b);
        send_line(0, 30, 1'b0, -1);
        send_line(320, 31, 1'b0, -1);
        check("reset no frame_done", 32'(done_cnt - d0), 32'd0);
        check("reset no writes", 32'(wr_cnt - w0), 32'd0);

        // Full frame, AA/55 pattern.
        d0 = done_cnt; w0 = wr_cnt; b0 = bad_cnt;
        pat_aa = 1'b1;
        req_pulse();
        exp_cap = 1'b1;
        vsync_pulse();
        check("full first addr pending", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < H; r++) send_line(320, r, 1'b0, -1);
        check_frame("full", d0, w0, b0, FULL_WR, 1'b0, FULL_LAST);
        if (wr_log.size() > w0) check("full first addr", 32'(wr_log[w0]), 32'd0);
        exp_cap = 1'b0;

        // Request mid-frame; second request during capture is ignored.
        pat_aa = 1'b0;
        d0 = done_cnt; w0 = wr_cnt; b0 = bad_cnt;
        vsync_pulse();
        send_line(320, 0, 1'b0, -1);
        send_line(320, 1, 1'b0, 50);
        check("midreq cap_busy", 32'(bus.cap_busy), 32'd1);
        send_line(320, 2, 1'b0, -1);
        check("midreq no early writes", 32'(wr_cnt - w0), 32'd0);
        exp_cap = 1'b1;
        vsync_pulse();
        send_line(320, 0, 1'b0, -1);
        send_line(320, 1, 1'b0, 10);
        send_line(320, 2, 1'b0, -1);
        send_line(320, 3, 1'b0, -1);
        vsync_pulse();
        check_frame("midreq", d0, w0, b0, B_WR, 1'b1, B_LAST);
        exp_cap = 1'b0;
        d0 = done_cnt; w0 = wr_cnt;
        vsync_pulse();
        send_line(320, 0, 1'b0, -1);
        vsync_pulse();
        check("no extra frame", 32'(done_cnt - d0), 32'd0);
        check("no extra writes", 32'(wr_cnt - w0), 32'd0);
        check("no extra busy", 32'(bus.cap_busy), 32'd0);

`ifndef CAPTURE_DECIM_EN
        // Long line 5, short line 6: per-line vectors.
        d0 = done_cnt; w0 = wr_cnt; b0 = bad_cnt;
        req_pulse();
        exp_cap = 1'b1;
        vsync_pulse();
        for (int i = 0; i < 8; i++) begin
            wl = wr_cnt;
            send_line(tbl[i].bytes, i, 1'b0, -1);
            check($sformatf("line%0d writes", i), 32'(wr_cnt - wl), 32'(tbl[i].exp_wr));
            first = (wr_log.size() > wl) ? wr_log[wl] : '1;
            check($sformatf("line%0d first addr", i), 32'(first), 32'(tbl[i].exp_first));
            check($sformatf("line%0d last addr", i), 32'(last_addr), 32'(tbl[i].exp_last));
        end
        vsync_pulse();
        check_frame("badlines", d0, w0, b0, 1279, 1'b1, 1279);
        exp_cap = 1'b0;
`endif

        // vsync coincident with the falling href of line 59.
        d0 = done_cnt; w0 = wr_cnt; b0 = bad_cnt;
        req_pulse();
        exp_cap = 1'b1;
        vsync_pulse();
        for (int r = 0; r < 59; r++) send_line(320, r, 1'b0, -1);
        send_line(320, 59, 1'b1, -1);
        check_frame("short frame", d0, w0, b0, D_WR, 1'b1, D_LAST);
        exp_cap = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
